// File: rtl/hilo_acc_unit.sv
// HI/LO special-register unit: direct writes, 2-cycle multiply-accumulate,
// divider pending interlock, read forwarding and MFHI/MFLO stall generation.
module hilo_acc_unit #(
    parameter int unsigned DW     = 32,
    parameter int unsigned BYPASS = 1,
    parameter int unsigned ACC_EN = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hi_we,
    input  logic [DW-1:0] hi_i,
    input  logic          lo_we,
    input  logic [DW-1:0] lo_i,
    input  logic          acc_valid,
    input  logic [1:0]    acc_op,
    input  logic [DW-1:0] acc_a,
    input  logic [DW-1:0] acc_b,
    input  logic          md_pend_set,
    input  logic          md_valid,
    input  logic [DW-1:0] md_hi,
    input  logic [DW-1:0] md_lo,
    input  logic          rd_req,
    output logic          issue_ready,
    output logic          rd_stall,
    output logic          busy,
    output logic [DW-1:0] hi_o,
    output logic [DW-1:0] lo_o
);

    typedef enum logic [1:0] {StIdle, StMul, StAdd, StMdWait} state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [2*DW-1:0] prod_q, prod_d;
    logic [1:0]      op_q, op_d;
    logic [2*DW-1:0] ext_a, ext_b, acc_sum;
    logic            acc_go;

    assign acc_go = (ACC_EN != 0) && acc_valid && (state_q == StIdle);

    // Operands are sign-extended only for signed ops, so one 2*DW multiplier
    // yields the correct low 2*DW product bits for both MADD/MSUB and the U forms.
    assign ext_a   = {{DW{acc_op[0] & acc_a[DW-1]}}, acc_a};
    assign ext_b   = {{DW{acc_op[0] & acc_b[DW-1]}}, acc_b};
    assign acc_sum = op_q[1] ? ({hi_q, lo_q} - prod_q) : ({hi_q, lo_q} + prod_q);

    // Next-state: FSM transitions and HI/LO/product register updates.
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        prod_d  = prod_q;
        op_d    = op_q;

        if (hi_we) hi_d = hi_i;
        if (lo_we) lo_d = lo_i;
        // Divider return overrides direct writes to either half.
        if (md_valid) begin
            hi_d = md_hi;
            lo_d = md_lo;
        end

        unique case (state_q)
            StIdle: begin
                if (acc_go) begin
                    prod_d  = ext_a * ext_b;
                    op_d    = acc_op;
                    state_d = StMul;
                end else if (md_pend_set) begin
                    state_d = StMdWait;
                end
            end
            StMul: state_d = StAdd;
            StAdd: begin
                // Accumulate result takes priority over any write this edge.
                {hi_d, lo_d} = acc_sum;
                state_d      = StIdle;
            end
            StMdWait: begin
                if (md_valid) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and architectural registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            hi_q    <= '0;
            lo_q    <= '0;
            prod_q  <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            prod_q  <= prod_d;
            op_q    <= op_d;
        end
    end

    // Read forwarding, status and decode stall.
    always_comb begin
        issue_ready = (state_q == StIdle);
        busy        = ~issue_ready;
        hi_o        = hi_q;
        lo_o        = lo_q;
        rd_stall    = 1'b0;
        if (BYPASS != 0) begin
            // Same-cycle write data is not forwarded in ADD: the ADD result wins.
            if (state_q != StAdd) begin
                if (md_valid) begin
                    hi_o = md_hi;
                    lo_o = md_lo;
                end else begin
                    if (hi_we) hi_o = hi_i;
                    if (lo_we) lo_o = lo_i;
                end
            end
            rd_stall = rd_req & ((state_q == StMul) || (state_q == StAdd) ||
                                 ((state_q == StMdWait) && !md_valid));
        end else begin
            rd_stall = rd_req & ((state_q != StIdle) | hi_we | lo_we | md_valid);
        end
    end

endmodule

// File: tb/tb_hilo_acc_unit.sv
// Scoreboard bench for hilo_acc_unit: one forwarding instance and one
// registered-output instance share stimulus; expectations are queued per cycle.
module tb_hilo_acc_unit;

    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          hi_we, lo_we, acc_valid, md_pend_set, md_valid, rd_req;
    logic [DW-1:0] hi_i, lo_i, acc_a, acc_b, md_hi, md_lo;
    logic [1:0]    acc_op;

    logic          ir0, st0, bz0, ir1, st1, bz1;
    logic [DW-1:0] ho0, lo0, ho1, lo1;

    hilo_acc_unit #(.DW(DW), .BYPASS(1), .ACC_EN(1)) u_dut_byp (
        .clk(clk), .rst_n(rst_n), .hi_we(hi_we), .hi_i(hi_i), .lo_we(lo_we), .lo_i(lo_i),
        .acc_valid(acc_valid), .acc_op(acc_op), .acc_a(acc_a), .acc_b(acc_b),
        .md_pend_set(md_pend_set), .md_valid(md_valid), .md_hi(md_hi), .md_lo(md_lo),
        .rd_req(rd_req), .issue_ready(ir0), .rd_stall(st0), .busy(bz0), .hi_o(ho0), .lo_o(lo0)
    );

    hilo_acc_unit #(.DW(DW), .BYPASS(0), .ACC_EN(1)) u_dut_reg (
        .clk(clk), .rst_n(rst_n), .hi_we(hi_we), .hi_i(hi_i), .lo_we(lo_we), .lo_i(lo_i),
        .acc_valid(acc_valid), .acc_op(acc_op), .acc_a(acc_a), .acc_b(acc_b),
        .md_pend_set(md_pend_set), .md_valid(md_valid), .md_hi(md_hi), .md_lo(md_lo),
        .rd_req(rd_req), .issue_ready(ir1), .rd_stall(st1), .busy(bz1), .hi_o(ho1), .lo_o(lo1)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         nm;
        int            cyc;
        int            sel;
        logic [DW-1:0] hi;
        logic [DW-1:0] lo;
        logic          stall;
        logic          ready;
        logic          busy;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc_cnt = 0;
    int   n_vec   = 0;
    int   n_bad   = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Monitor: compare every expectation queued for the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
            logic [DW-1:0] ah, al;
            logic          as, ar, ab;
            mon_e = sb.pop_front();
            if (mon_e.sel == 0) begin
                ah = ho0; al = lo0; as = st0; ar = ir0; ab = bz0;
            end else begin
                ah = ho1; al = lo1; as = st1; ar = ir1; ab = bz1;
            end
            n_vec = n_vec + 1;
            if (mon_e.cyc != cyc_cnt || ah !== mon_e.hi || al !== mon_e.lo ||
                as !== mon_e.stall || ar !== mon_e.ready || ab !== mon_e.busy) begin
                n_bad = n_bad + 1;
                $display("FAIL %s dut%0d cyc%0d: got hi=%h lo=%h stall=%b ready=%b busy=%b, want hi=%h lo=%h stall=%b ready=%b busy=%b",
                         mon_e.nm, mon_e.sel, cyc_cnt, ah, al, as, ar, ab,
                         mon_e.hi, mon_e.lo, mon_e.stall, mon_e.ready, mon_e.busy);
            end
        end
    end

    task automatic expect_vec(input string nm, input int sel, input logic [DW-1:0] h,
                              input logic [DW-1:0] l, input logic st, input logic rdy,
                              input logic bz);
        exp_t e;
        e.nm = nm; e.cyc = cyc_cnt; e.sel = sel; e.hi = h; e.lo = l;
        e.stall = st; e.ready = rdy; e.busy = bz;
        sb.push_back(e);
    endtask

    task automatic exp_both(input string nm, input logic [DW-1:0] h, input logic [DW-1:0] l,
                            input logic st, input logic rdy, input logic bz);
        expect_vec(nm, 0, h, l, st, rdy, bz);
        expect_vec(nm, 1, h, l, st, rdy, bz);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        hi_we = 1'b0; lo_we = 1'b0; acc_valid = 1'b0; md_pend_set = 1'b0; md_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: stimulus did not complete, required completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; rd_req = 1'b1;
        hi_we = 1'b0; lo_we = 1'b0; acc_valid = 1'b0; md_pend_set = 1'b0; md_valid = 1'b0;
        hi_i = '0; lo_i = '0; acc_a = '0; acc_b = '0; md_hi = '0; md_lo = '0; acc_op = 2'b00;

        next(); exp_both("reset", 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;

        // Direct HI write: forwarded vs. stalled
        next(); hi_we = 1'b1; hi_i = 32'hDEAD_BEEF;
        expect_vec("hi_bypass", 0, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1, 1'b0);
        expect_vec("hi_reg_stall", 1, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        next(); exp_both("hi_written", 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1, 1'b0);

        // MADD: {0,5} + (-2 * 3) = -1
        next(); hi_we = 1'b1; hi_i = 32'h0; lo_we = 1'b1; lo_i = 32'h5;
        expect_vec("madd_setup", 0, 32'h0, 32'h5, 1'b0, 1'b1, 1'b0);
        expect_vec("madd_setup", 1, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b1, 1'b0);
        next(); acc_valid = 1'b1; acc_op = 2'b01; acc_a = 32'hFFFF_FFFE; acc_b = 32'h3;
        exp_both("madd_issue", 32'h0, 32'h5, 1'b0, 1'b1, 1'b0);
        next(); acc_op = 2'b00; acc_a = 32'h0;  // op must already be latched
        exp_both("madd_mul", 32'h0, 32'h5, 1'b1, 1'b0, 1'b1);
        next(); exp_both("madd_add", 32'h0, 32'h5, 1'b1, 1'b0, 1'b1);
        next(); exp_both("madd_result", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);

        // MSUBU: {0,1} - 1 = 0, then 0 - 1 wraps to all ones
        next(); hi_we = 1'b1; hi_i = 32'h0; lo_we = 1'b1; lo_i = 32'h1;
        expect_vec("msubu_setup", 0, 32'h0, 32'h1, 1'b0, 1'b1, 1'b0);
        expect_vec("msubu_setup", 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
        next(); acc_valid = 1'b1; acc_op = 2'b10; acc_a = 32'h1; acc_b = 32'h1;
        exp_both("msubu_issue", 32'h0, 32'h1, 1'b0, 1'b1, 1'b0);
        next(); exp_both("msubu_mul", 32'h0, 32'h1, 1'b1, 1'b0, 1'b1);
        next(); exp_both("msubu_add", 32'h0, 32'h1, 1'b1, 1'b0, 1'b1);
        next(); exp_both("msubu_zero", 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        acc_valid = 1'b1; acc_op = 2'b10; acc_a = 32'h1; acc_b = 32'h1;
        next(); exp_both("msubu2_mul", 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        next(); exp_both("msubu2_add", 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        next(); exp_both("msubu_wrap", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);

        // MADDU: 0xFFFFFFFF * 2 unsigned = 0x1_FFFFFFFE
        next(); hi_we = 1'b1; hi_i = 32'h0; lo_we = 1'b1; lo_i = 32'h0;
        expect_vec("maddu_setup", 0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        expect_vec("maddu_setup", 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
        next(); acc_valid = 1'b1; acc_op = 2'b00; acc_a = 32'hFFFF_FFFF; acc_b = 32'h2;
        exp_both("maddu_issue", 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        next(); exp_both("maddu_mul", 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        next(); exp_both("maddu_add", 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        next(); exp_both("maddu_unsigned", 32'h1, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0);

        // Divide interlock
        next(); md_pend_set = 1'b1;
        exp_both("md_issue", 32'h1, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            next(); exp_both("md_wait", 32'h1, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1);
        end
        next(); md_valid = 1'b1; md_hi = 32'h3; md_lo = 32'h7;
        expect_vec("md_return", 0, 32'h3, 32'h7, 1'b0, 1'b0, 1'b1);
        expect_vec("md_return", 1, 32'h1, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1);
        next(); exp_both("md_done", 32'h3, 32'h7, 1'b0, 1'b1, 1'b0);

        // md_valid in IDLE overrides same-cycle direct writes
        next(); md_valid = 1'b1; md_hi = 32'h9; md_lo = 32'hA;
        hi_we = 1'b1; hi_i = 32'hFF; lo_we = 1'b1; lo_i = 32'hEE;
        expect_vec("md_override", 0, 32'h9, 32'hA, 1'b0, 1'b1, 1'b0);
        expect_vec("md_override", 1, 32'h3, 32'h7, 1'b1, 1'b1, 1'b0);
        next(); exp_both("md_direct", 32'h9, 32'hA, 1'b0, 1'b1, 1'b0);

        // Write in MUL is accumulated; write in ADD is discarded
        acc_valid = 1'b1; acc_op = 2'b00; acc_a = 32'h2; acc_b = 32'h3;
        next(); hi_we = 1'b1; hi_i = 32'h1;
        expect_vec("mul_write", 0, 32'h1, 32'hA, 1'b1, 1'b0, 1'b1);
        expect_vec("mul_write", 1, 32'h9, 32'hA, 1'b1, 1'b0, 1'b1);
        next(); hi_we = 1'b1; hi_i = 32'h55;
        exp_both("add_write_suppressed", 32'h1, 32'hA, 1'b1, 1'b0, 1'b1);
        next(); exp_both("mul_write_included", 32'h1, 32'h10, 1'b0, 1'b1, 1'b0);

        // Reset asserted while in MUL
        acc_valid = 1'b1; acc_op = 2'b00; acc_a = 32'h1; acc_b = 32'h1;
        next(); rst_n = 1'b0;
        exp_both("reset_in_mul", 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        next(); rst_n = 1'b1;
        exp_both("after_reset", 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        next(); next();
        exp_both("no_partial_write", 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
            n_bad = n_bad + sb.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/hilo_acc_unit.md
Name: hilo_acc_unit

Overview:
- Parametrised HI/LO special-register unit for the MIPS core.
- Holds the architectural HI/LO pair and accepts direct writes (MTHI/MTLO, single-cycle MULT) with per-half enables.
- Adds a 2-cycle multiply-accumulate path (MADD/MADDU/MSUB/MSUBU) and a pending-result interlock for the multi-cycle divider.
- Drives read forwarding and the MFHI/MFLO stall to decode.

Parameters:
- DW, 32, width of each of HI and LO.
- BYPASS, 1, 1 = same-cycle write data is forwarded to hi_o/lo_o; 0 = registered outputs only, with extra stall.
- ACC_EN, 1, 1 = accumulate path present; 0 = acc_valid is ignored and the MUL/ADD states are unreachable.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- hi_we  in  1  direct HI write enable.
- hi_i  in  DW  direct HI write data.
- lo_we  in  1  direct LO write enable.
- lo_i  in  DW  direct LO write data.
- acc_valid  in  1  accumulate request.
- acc_op  in  2  00 MADDU, 01 MADD, 10 MSUBU, 11 MSUB.
- acc_a  in  DW  multiplicand.
- acc_b  in  DW  multiplier.
- md_pend_set  in  1  divider issued; HI/LO result is pending.
- md_valid  in  1  divider result return.
- md_hi  in  DW  divider remainder.
- md_lo  in  DW  divider quotient.
- rd_req  in  1  decode holds MFHI/MFLO.
- issue_ready  out  1  unit can accept acc_valid or md_pend_set.
- rd_stall  out  1  decode must hold the read.
- busy  out  1  FSM is not IDLE.
- hi_o  out  DW  HI read value.
- lo_o  out  DW  LO read value.

Behaviour:
- Reset (async, rst_n=0): hi_reg=0, lo_reg=0, prod_reg=0, state=IDLE. Outputs: hi_o=0, lo_o=0, busy=0, issue_ready=1, rd_stall=0. Reset mid-operation abandons any accumulate or pending divide; no partial write occurs.
- States: IDLE, MUL, ADD, MD_WAIT. issue_ready = (state==IDLE); busy = ~issue_ready.
- Direct writes:
  - Any state: hi_we loads hi_i and lo_we loads lo_i at the edge; the two halves are independent.
  - Exception: in ADD, the accumulate result overrides direct writes at that edge.
  - md_valid loads both halves (md_hi, md_lo) and overrides hi_we/lo_we in the same cycle.
- Accumulate (ACC_EN=1):
  - Accepted when acc_valid & issue_ready.
  - Edge T: prod_reg <= acc_a*acc_b, 2*DW bits; signed for acc_op[0]=1, unsigned otherwise. state <= MUL.
  - MUL: state <= ADD at the next edge (pipeline bubble for the multiplier).
  - ADD: {hi,lo} <= {hi_reg,lo_reg} + prod_reg (acc_op[1]=0) or − prod_reg (acc_op[1]=1), modulo 2^(2*DW), no overflow flag. state <= IDLE.
  - The ADD step reads current registers, so direct writes landing at edge T or in MUL are included.
  - acc_op is latched at acceptance.
  - New HI/LO is visible on registered outputs from cycle T+3.
- Divide interlock:
  - md_pend_set & issue_ready & ~acc_valid: state <= MD_WAIT.
  - If acc_valid is also asserted, the accumulate wins and md_pend_set is dropped; the issuer must not do this.
  - MD_WAIT: stays until md_valid, then writes HI/LO and returns to IDLE.
  - md_valid in IDLE is accepted as a direct both-half write.
  - md_pend_set when not IDLE is ignored.
- Read outputs:
  - BYPASS=1: hi_o = md_valid ? md_hi : hi_we ? hi_i : hi_reg; lo_o likewise. Override is suppressed in ADD.
  - BYPASS=0: hi_o = hi_reg, lo_o = lo_reg.
- Stall:
  - BYPASS=1: rd_stall = rd_req & (state is MUL or ADD, or (MD_WAIT & ~md_valid)).
  - BYPASS=0: rd_stall = rd_req & (state!=IDLE | hi_we | lo_we | md_valid).
  - rd_stall is purely combinational and never asserted without rd_req.

Test Plan:
- Reset, then rd_req=1 → hi_o=0, lo_o=0, rd_stall=0, issue_ready=1. Assert rst_n=0 while in MUL → outputs clear immediately and state returns to IDLE.
- hi_we=1, hi_i=32'hDEAD_BEEF, lo_we=0, BYPASS=1 → hi_o=DEADBEEF in the same cycle, lo unchanged. Repeat with BYPASS=0 and rd_req=1 → rd_stall=1 for that cycle; hi_o=DEADBEEF the next cycle.
- HI=0, LO=5, MADD with acc_a=-2, acc_b=3 → busy for 2 cycles, rd_stall during MUL/ADD; final HI=FFFF_FFFF, LO=FFFF_FFFF (−1).
- HI=0, LO=1, MSUBU with acc_a=acc_b=1 → {HI,LO}=0. Then MSUBU once more → HI=LO=FFFF_FFFF (wrap-around).
- md_pend_set, then 10 idle cycles with rd_req=1 → rd_stall=1 throughout. On md_valid with md_hi=3, md_lo=7 → rd_stall=0 that cycle (BYPASS=1), hi_o=3, lo_o=7, state=IDLE next.
- In MUL, hi_we with hi_i=1 → included in the ADD result. In ADD, hi_we → discarded; the accumulate result is stored.
